fetch_queue_mp: RTL and testbench

Parametrised multi-port instruction fetch queue between the fetch unit and a configurable array of decoders. Accepts variable-length bundles (1..instructionsPerBundle instructions), stores each instruction with its address and major ID, and issues up to numDecoders instructions per cycle in program order to whichever decoders report available. Unlike the previous fixed 4-wide queue, it uses count-based occupancy so every entry is usable, and it supports a flush.

---
 rtl/fetch_queue_mp.sv | 177 +++++++++++++++++
 tb/tb_fetch_queue_mp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_mp.sv
// fetch_queue_mp: multi-port in-order instruction fetch queue with count-based occupancy and flush.
// Define FETCH_QUEUE_STATS_EN to add the highWater_o / droppedWrites_o statistics outputs.
module fetch_queue_mp #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int instructionsPerBundle   = 4,
    parameter int numDecoders             = 4,
    parameter int instructionCounterWidth = 64,
    parameter int queueIndexBits          = 7,
    parameter int lenBits                 = $clog2(instructionsPerBundle)
) (
    input  logic                                            clock_i,
    input  logic                                            reset_i,
    input  logic                                            flush_i,
    input  logic                                            bundleWrite_i,
    input  logic [addressWidth-1:0]                         bundleAddress_i,
    input  logic [lenBits-1:0]                              bundleLen_i,
    input  logic [instructionCounterWidth-1:0]              bundleStartMajId_i,
    input  logic [instructionsPerBundle*instructionWidth-1:0] bundle_i,
    input  logic [numDecoders-1:0]                          decodeAvailable_i,
    output logic [numDecoders-1:0]                          decoderEn_o,
    output logic [numDecoders*instructionWidth-1:0]         decoderIns_o,
    output logic [numDecoders*addressWidth-1:0]             decoderAddr_o,
    output logic [numDecoders*instructionCounterWidth-1:0]  decoderMajId_o,
    output logic [queueIndexBits-1:0]                       front_o,
    output logic [queueIndexBits-1:0]                       back_o,
    output logic [queueIndexBits:0]                         count_o,
    output logic                                            isFull_o,
    output logic                                            isEmpty_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [queueIndexBits:0]                         highWater_o,
    output logic [31:0]                                     droppedWrites_o
`endif
);

    localparam int DEPTH = 1 << queueIndexBits;
    localparam int CW    = queueIndexBits + 1;
    localparam int IW    = instructionWidth;
    localparam int AW    = addressWidth;
    localparam int MW    = instructionCounterWidth;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] IPB_C   = CW'(instructionsPerBundle);

    logic [IW-1:0] ins_mem_r   [DEPTH];
    logic [AW-1:0] addr_mem_r  [DEPTH];
    logic [MW-1:0] majid_mem_r [DEPTH];

    logic [queueIndexBits-1:0] front_r;
    logic [queueIndexBits-1:0] back_r;
    logic [CW-1:0]             count_r;
    logic                      full_r;
    logic                      empty_r;
    logic [numDecoders-1:0]    en_r;
    logic [numDecoders*IW-1:0] ins_out_r;
    logic [numDecoders*AW-1:0] addr_out_r;
    logic [numDecoders*MW-1:0] majid_out_r;

    logic [CW-1:0]          n_s;
    logic                   wr_acc_s;
    logic [CW-1:0]          avail_cnt_s;
    logic [CW-1:0]          m_s;
    logic [CW-1:0]          count_next_s;
    logic [CW-1:0]          rank_s [numDecoders];
    logic [numDecoders-1:0] load_s;

    // Acceptance, issue width and per-port rank among the available decoders.
    always_comb begin
        n_s         = CW'(bundleLen_i) + {{(CW-1){1'b0}}, 1'b1};
        wr_acc_s    = bundleWrite_i & ~full_r & ~flush_i;
        avail_cnt_s = {CW{1'b0}};
        load_s      = {numDecoders{1'b0}};
        for (int k = 0; k < numDecoders; k++) begin
            // rank = number of available ports below k, i.e. which queued entry port k takes
            rank_s[k]   = avail_cnt_s;
            avail_cnt_s = avail_cnt_s + CW'(decodeAvailable_i[k]);
        end
        if (avail_cnt_s < count_r) begin
            m_s = avail_cnt_s;
        end else begin
            m_s = count_r;
        end
        for (int k = 0; k < numDecoders; k++) begin
            load_s[k] = decodeAvailable_i[k] & (rank_s[k] < m_s);
        end
        if (wr_acc_s) begin
            count_next_s = count_r + n_s - m_s;
        end else begin
            count_next_s = count_r - m_s;
        end
    end

    // Pointers, occupancy, status flags and registered decoder ports.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            front_r     <= {queueIndexBits{1'b0}};
            back_r      <= {queueIndexBits{1'b0}};
            count_r     <= {CW{1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            en_r        <= {numDecoders{1'b0}};
            ins_out_r   <= {(numDecoders*IW){1'b0}};
            addr_out_r  <= {(numDecoders*AW){1'b0}};
            majid_out_r <= {(numDecoders*MW){1'b0}};
        end else if (flush_i) begin
            front_r <= {queueIndexBits{1'b0}};
            back_r  <= {queueIndexBits{1'b0}};
            count_r <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            en_r    <= {numDecoders{1'b0}};
        end else begin
            front_r <= front_r + queueIndexBits'(m_s);
            if (wr_acc_s) begin
                back_r <= back_r + queueIndexBits'(n_s);
            end
            count_r <= count_next_s;
            full_r  <= (DEPTH_C - count_next_s) < IPB_C;
            empty_r <= (count_next_s == {CW{1'b0}});
            en_r    <= load_s;
            for (int k = 0; k < numDecoders; k++) begin
                if (load_s[k]) begin
                    ins_out_r[k*IW +: IW]   <= ins_mem_r[front_r + queueIndexBits'(rank_s[k])];
                    addr_out_r[k*AW +: AW]  <= addr_mem_r[front_r + queueIndexBits'(rank_s[k])];
                    majid_out_r[k*MW +: MW] <= majid_mem_r[front_r + queueIndexBits'(rank_s[k])];
                end
            end
        end
    end

    // Entry storage; only accepted bundle slots are written.
    always_ff @(posedge clock_i) begin
        if (reset_i && wr_acc_s) begin
            for (int i = 0; i < instructionsPerBundle; i++) begin
                if (i < int'(n_s)) begin
                    ins_mem_r[back_r + queueIndexBits'(i)]   <= bundle_i[i*IW +: IW];
                    addr_mem_r[back_r + queueIndexBits'(i)]  <= bundleAddress_i + (AW'(i) << 2'd2);
                    majid_mem_r[back_r + queueIndexBits'(i)] <= bundleStartMajId_i + MW'(i);
                end
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [CW-1:0] high_water_r;
    logic [31:0]   dropped_r;

    // High-water mark survives flush; dropped-write counter saturates.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            high_water_r <= {CW{1'b0}};
            dropped_r    <= 32'd0;
        end else begin
            if (!flush_i && (count_next_s > high_water_r)) begin
                high_water_r <= count_next_s;
            end
            if (bundleWrite_i && full_r && !flush_i && (dropped_r != 32'hFFFF_FFFF)) begin
                dropped_r <= dropped_r + 32'd1;
            end
        end
    end

    assign highWater_o     = high_water_r;
    assign droppedWrites_o = dropped_r;
`endif

    assign decoderEn_o    = en_r;
    assign decoderIns_o   = ins_out_r;
    assign decoderAddr_o  = addr_out_r;
    assign decoderMajId_o = majid_out_r;
    assign front_o        = front_r;
    assign back_o         = back_r;
    assign count_o        = count_r;
    assign isFull_o       = full_r;
    assign isEmpty_o      = empty_r;

endmodule

// File: tb/tb_fetch_queue_mp.sv
// Self-checking bench for fetch_queue_mp: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue_mp;
    localparam int AW = 64, IW = 32, IPB = 4, ND = 4, MW = 64, QIB = 7, LB = 2, DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_i, flush_i, bundleWrite_i;
    logic [AW-1:0]        bundleAddress_i;
    logic [LB-1:0]        bundleLen_i;
    logic [MW-1:0]        bundleStartMajId_i;
    logic [IPB*IW-1:0]    bundle_i;
    logic [ND-1:0]        decodeAvailable_i;
    logic [ND-1:0]        decoderEn_o;
    logic [ND*IW-1:0]     decoderIns_o;
    logic [ND*AW-1:0]     decoderAddr_o;
    logic [ND*MW-1:0]     decoderMajId_o;
    logic [QIB-1:0]       front_o, back_o;
    logic [QIB:0]         count_o;
    logic                 isFull_o, isEmpty_o;
`ifdef FETCH_QUEUE_STATS_EN
    logic [QIB:0]         highWater_o;
    logic [31:0]          droppedWrites_o;
`endif

    fetch_queue_mp dut (
        .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i), .bundleWrite_i(bundleWrite_i),
        .bundleAddress_i(bundleAddress_i), .bundleLen_i(bundleLen_i),
        .bundleStartMajId_i(bundleStartMajId_i), .bundle_i(bundle_i),
        .decodeAvailable_i(decodeAvailable_i), .decoderEn_o(decoderEn_o),
        .decoderIns_o(decoderIns_o), .decoderAddr_o(decoderAddr_o),
        .decoderMajId_o(decoderMajId_o), .front_o(front_o), .back_o(back_o),
        .count_o(count_o), .isFull_o(isFull_o), .isEmpty_o(isEmpty_o)
`ifdef FETCH_QUEUE_STATS_EN
        , .highWater_o(highWater_o), .droppedWrites_o(droppedWrites_o)
`endif
    );

    typedef struct { logic [IW-1:0] ins; logic [AW-1:0] addr; logic [MW-1:0] maj; } entry_t;
    entry_t q[$];
    int m_front, m_back, hw, dropped;
    logic [ND-1:0]    exp_en;
    logic [ND*IW-1:0] exp_ins;
    logic [ND*AW-1:0] exp_addr;
    logic [ND*MW-1:0] exp_maj;
    int checks = 0, errors = 0;

    // Reference model: advance one edge from the inputs currently driven.
    task automatic model_edge();
        int avail, m, issued;
        bit full;
        entry_t e;
        if (!reset_i) begin
            q.delete(); m_front = 0; m_back = 0; hw = 0; dropped = 0;
            exp_en = '0; exp_ins = '0; exp_addr = '0; exp_maj = '0;
        end else if (flush_i) begin
            q.delete(); m_front = 0; m_back = 0; exp_en = '0;
        end else begin
            full   = (DEPTH - q.size()) < IPB;
            avail  = $countones(decodeAvailable_i);
            m      = (avail < q.size()) ? avail : q.size();
            issued = 0;
            for (int k = 0; k < ND; k++) begin
                if (decodeAvailable_i[k] && issued < m) begin
                    e = q.pop_front();
                    exp_en[k] = 1'b1;
                    exp_ins[k*IW +: IW] = e.ins;
                    exp_addr[k*AW +: AW] = e.addr;
                    exp_maj[k*MW +: MW] = e.maj;
                    issued++;
                end else begin
                    exp_en[k] = 1'b0;
                end
            end
            m_front = (m_front + m) % DEPTH;
            if (bundleWrite_i && !full) begin
                for (int i = 0; i <= int'(bundleLen_i); i++) begin
                    e.ins  = bundle_i[i*IW +: IW];
                    e.addr = bundleAddress_i + 64'(4 * i);
                    e.maj  = bundleStartMajId_i + 64'(i);
                    q.push_back(e);
                end
                m_back = (m_back + int'(bundleLen_i) + 1) % DEPTH;
            end else if (bundleWrite_i) begin
                dropped++;
            end
            if (q.size() > hw) hw = q.size();
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [LB-1:0] len, input logic [AW-1:0] addr,
                         input logic [MW-1:0] maj, input logic [IPB*IW-1:0] b, input logic [ND-1:0] av);
        bundleWrite_i = w; bundleLen_i = len; bundleAddress_i = addr;
        bundleStartMajId_i = maj; bundle_i = b; decodeAvailable_i = av;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 2'd0, '0, '0, '0, 4'h0);
        tick();
        reset_i = 1'b1;
        checks++; if (isEmpty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", isEmpty_o); end
        checks++; if (isFull_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", isFull_o); end
        checks++; if (front_o !== 7'd0 || back_o !== 7'd0) begin errors++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", front_o, back_o); end
        checks++; if (count_o !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++; if (decoderEn_o !== 4'b0000) begin errors++; $display("FAIL reset_en got %b want 0000", decoderEn_o); end
    endtask

    task automatic test_full_bundle();
        drive(1'b1, 2'd3, 64'h1000, 64'd10, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 4'h0);
        tick();
        checks++; if (back_o !== 7'd4 || count_o !== 8'd4) begin errors++; $display("FAIL fb_enqueue got back %0d count %0d want 4 4", back_o, count_o); end
        drive(1'b0, 2'd0, '0, '0, '0, 4'hF);
        tick();
        checks++; if (decoderEn_o !== 4'b1111) begin errors++; $display("FAIL fb_en got %b want 1111", decoderEn_o); end
        checks++; if (decoderIns_o !== {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}) begin errors++; $display("FAIL fb_ins got %h", decoderIns_o); end
        checks++; if (decoderAddr_o !== {64'h100C, 64'h1008, 64'h1004, 64'h1000}) begin errors++; $display("FAIL fb_addr got %h", decoderAddr_o); end
        checks++; if (decoderMajId_o !== {64'd13, 64'd12, 64'd11, 64'd10}) begin errors++; $display("FAIL fb_majid got %h", decoderMajId_o); end
        checks++; if (isEmpty_o !== 1'b1) begin errors++; $display("FAIL fb_empty got %b want 1", isEmpty_o); end
    endtask

    task automatic test_sparse_ports();
        drive(1'b1, 2'd3, 64'h2000, 64'd20, {32'h103, 32'h102, 32'h101, 32'h100}, 4'h0);
        tick();
        drive(1'b1, 2'd3, 64'h2010, 64'd24, {32'h107, 32'h106, 32'h105, 32'h104}, 4'h0);
        tick();
        drive(1'b0, 2'd0, '0, '0, '0, 4'b0101);
        tick();
        checks++; if (decoderEn_o !== 4'b0101) begin errors++; $display("FAIL sp_en got %b want 0101", decoderEn_o); end
        checks++; if (decoderIns_o[31:0] !== 32'h100 || decoderIns_o[95:64] !== 32'h101) begin errors++; $display("FAIL sp_order got p0 %h p2 %h want 100 101", decoderIns_o[31:0], decoderIns_o[95:64]); end
        checks++; if (decoderIns_o !== exp_ins) begin errors++; $display("FAIL sp_hold got %h want %h", decoderIns_o, exp_ins); end
        checks++; if (count_o !== 8'd6 || front_o !== 7'd6) begin errors++; $display("FAIL sp_count got count %0d front %0d want 6 6", count_o, front_o); end
        drive(1'b0, 2'd0, '0, '0, '0, 4'hF);
        tick();
        tick();
        checks++; if (decoderEn_o !== 4'b0011) begin errors++; $display("FAIL sp_tail_en got %b want 0011", decoderEn_o); end
        checks++; if (decoderIns_o[63:0] !== {32'h107, 32'h106}) begin errors++; $display("FAIL sp_tail_ins got %h want 0000010700000106", decoderIns_o[63:0]); end
    endtask

    task automatic test_fill();
        flush_i = 1'b1; drive(1'b0, 2'd0, '0, '0, '0, 4'h0); tick(); flush_i = 1'b0;
        for (int b = 0; b < 32; b++) begin
            drive(1'b1, 2'd3, 64'(b * 16), 64'(b * 4), {$urandom, $urandom, $urandom, $urandom}, 4'h0);
            tick();
            if (b == 30) begin
                checks++; if (count_o !== 8'd124 || isFull_o !== 1'b0) begin errors++; $display("FAIL fill31 got count %0d full %b want 124 0", count_o, isFull_o); end
            end
        end
        checks++; if (count_o !== 8'd128 || isFull_o !== 1'b1) begin errors++; $display("FAIL fill32 got count %0d full %b want 128 1", count_o, isFull_o); end
        checks++; if (back_o !== 7'd0 || front_o !== 7'd0) begin errors++; $display("FAIL fill_ptrs got %0d/%0d want 0/0", back_o, front_o); end
        drive(1'b1, 2'd3, 64'h9000, 64'd0, {4{32'hDEADBEEF}}, 4'h0);
        tick();
        checks++; if (count_o !== 8'd128) begin errors++; $display("FAIL fill_drop got count %0d want 128", count_o); end
`ifdef FETCH_QUEUE_STATS_EN
        checks++; if (droppedWrites_o !== 32'(dropped) || highWater_o !== 8'(hw)) begin errors++; $display("FAIL fill_stats got drop %0d hw %0d want %0d %0d", droppedWrites_o, highWater_o, dropped, hw); end
`endif
    endtask

    task automatic test_full_simultaneous();
        drive(1'b1, 2'd3, 64'hA000, 64'd500, {4{32'h12345678}}, 4'hF);
        tick();
        checks++; if (count_o !== 8'd124 || decoderEn_o !== 4'hF) begin errors++; $display("FAIL fs_drop got count %0d en %b want 124 1111", count_o, decoderEn_o); end
        checks++; if (decoderIns_o !== exp_ins || decoderAddr_o !== exp_addr) begin errors++; $display("FAIL fs_data got %h want %h", decoderIns_o, exp_ins); end
        drive(1'b1, 2'd1, 64'hB000, 64'd600, {32'h0, 32'h0, 32'h22222222, 32'h11111111}, 4'b0011);
        tick();
        checks++; if (count_o !== 8'd124 || isFull_o !== 1'b0) begin errors++; $display("FAIL fs_both got count %0d full %b want 124 0", count_o, isFull_o); end
    endtask

    task automatic test_flush();
        flush_i = 1'b1; drive(1'b0, 2'd0, '0, '0, '0, 4'h0); tick(); flush_i = 1'b0;
        drive(1'b1, 2'd3, 64'hC000, 64'd1, {4{32'h33333333}}, 4'h0); tick();
        drive(1'b1, 2'd3, 64'hC010, 64'd5, {4{32'h44444444}}, 4'h0); tick();
        drive(1'b0, 2'd0, '0, '0, '0, 4'b0011); tick();
        checks++; if (count_o !== 8'd6) begin errors++; $display("FAIL fl_pre got count %0d want 6", count_o); end
        flush_i = 1'b1;
        drive(1'b1, 2'd1, 64'hD000, 64'd9, {32'h0, 32'h0, 32'hFFFFFFFF, 32'hEEEEEEEE}, 4'hF);
        tick();
        flush_i = 1'b0;
        checks++; if (count_o !== 8'd0 || front_o !== 7'd0 || back_o !== 7'd0) begin errors++; $display("FAIL fl_state got count %0d front %0d back %0d want 0 0 0", count_o, front_o, back_o); end
        checks++; if (decoderEn_o !== 4'b0000 || isEmpty_o !== 1'b1) begin errors++; $display("FAIL fl_en got %b empty %b want 0000 1", decoderEn_o, isEmpty_o); end
        drive(1'b1, 2'd2, 64'hE000, 64'd3, {4{32'h55555555}}, 4'h0); tick();
        reset_i = 1'b0; drive(1'b1, 2'd3, 64'hE100, 64'd7, {4{32'h66666666}}, 4'hF); tick(); reset_i = 1'b1;
        checks++; if (count_o !== 8'd0 || decoderEn_o !== 4'b0000 || decoderIns_o !== '0 || isEmpty_o !== 1'b1) begin errors++; $display("FAIL fl_reset got count %0d en %b ins %h", count_o, decoderEn_o, decoderIns_o); end
    endtask

    task automatic test_random();
        reset_i = 1'b0; tick(); reset_i = 1'b1;
        for (int c = 0; c < 600; c++) begin
            flush_i = ($urandom_range(0, 79) == 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  (c % 200 < 100) ? 4'($urandom & $urandom) : 4'($urandom));
            tick();
            checks++; if (decoderEn_o !== exp_en) begin errors++; $display("FAIL rnd_en cyc %0d got %b want %b", c, decoderEn_o, exp_en); end
            checks++; if (decoderIns_o !== exp_ins || decoderAddr_o !== exp_addr || decoderMajId_o !== exp_maj) begin errors++; $display("FAIL rnd_data cyc %0d got ins %h want %h", c, decoderIns_o, exp_ins); end
            checks++; if (count_o !== 8'(q.size()) || front_o !== 7'(m_front) || back_o !== 7'(m_back)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", c, count_o, front_o, back_o, q.size(), m_front, m_back); end
            checks++; if (isFull_o !== ((DEPTH - q.size()) < IPB) || isEmpty_o !== (q.size() == 0)) begin errors++; $display("FAIL rnd_status cyc %0d got full %b empty %b", c, isFull_o, isEmpty_o); end
`ifdef FETCH_QUEUE_STATS_EN
            checks++; if (droppedWrites_o !== 32'(dropped) || highWater_o !== 8'(hw)) begin errors++; $display("FAIL rnd_stats cyc %0d got %0d/%0d want %0d/%0d", c, droppedWrites_o, highWater_o, dropped, hw); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_full_bundle();
        test_sparse_ports();
        test_fill();
        test_full_simultaneous();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
